// File: rtl/rf_update_sched_pkg.sv
// Shared configuration for the register-file update scheduler:
// default widths, flush sequencer states and small helpers.
package rf_update_sched_pkg;

   localparam int ROB_SIZE_BIT = 4;
   localparam int CQ_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      CLEAR
   } sched_state_t;

   // Register x0 is hardwired, so writes aimed at it carry no information for the RF.
   function automatic logic rd_is_real(input logic [4:0] rd);
      return rd != 5'd0;
   endfunction

endpackage

// File: rtl/rf_update_sched_if.sv
// Commit and rename handshakes between the ROB/decoder (master) and the scheduler (slave).
interface rf_update_sched_if #(
   parameter int TAG_W = rf_update_sched_pkg::ROB_SIZE_BIT
);

   logic             commit_valid;
   logic             commit_ready;
   logic [4:0]       commit_rd;
   logic [TAG_W-1:0] commit_tag;
   logic [31:0]      commit_val;

   logic             rename_valid;
   logic             rename_ready;
   logic [4:0]       rename_rd;
   logic [TAG_W-1:0] rename_tag;

   modport master (
      output commit_valid, commit_rd, commit_tag, commit_val,
      output rename_valid, rename_rd, rename_tag,
      input  commit_ready, rename_ready
   );

   modport slave (
      input  commit_valid, commit_rd, commit_tag, commit_val,
      input  rename_valid, rename_rd, rename_tag,
      output commit_ready, rename_ready
   );

endinterface

// File: rtl/rf_commit_fifo.sv
// Synchronous FIFO holding commit writes waiting for the RF value port.
// No internal bypass; en low freezes pointers and storage.
module rf_commit_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             en,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int            PW       = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (en) begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

endmodule

// File: rtl/rf_update_sched.sv
// Owns the RF value-write and dependency-write ports: queues ROB commits,
// forwards decoder renames and sequences drain-then-clear on a mispredict flush.
module rf_update_sched import rf_update_sched_pkg::*; #(
   parameter int TAG_W    = ROB_SIZE_BIT,
   parameter int CQ_DEPTH = CQ_DEPTH_DEF
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   rf_update_sched_if.slave   bus,
   input  logic               flush_req,
   output logic               flush_busy,
   output logic               is_update_val_in,
   output logic [4:0]         update_val_id,
   output logic [TAG_W-1:0]   update_val_dep,
   output logic [31:0]        update_val,
   output logic               is_update_dep_in,
   output logic [4:0]         update_dep_id,
   output logic [TAG_W-1:0]   update_dep,
   output logic               rob_clear
);

   typedef struct packed {
      logic [4:0]       rd;
      logic [TAG_W-1:0] tag;
      logic [31:0]      val;
   } commit_entry_t;

   sched_state_t  state;
   sched_state_t  state_nxt;
   commit_entry_t commit_entry;
   commit_entry_t fifo_head;
   logic          fifo_empty;
   logic          fifo_full;
   logic          commit_fire;
   logic          rename_fire;
   logic          commit_writes;
   logic          fifo_push;
   logic          fifo_pop;

   assign commit_entry = {bus.commit_rd, bus.commit_tag, bus.commit_val};
   assign flush_busy   = (state != IDLE);

   rf_commit_fifo #(
      .WIDTH ($bits(commit_entry_t)),
      .DEPTH (CQ_DEPTH)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .en        (rdy_in),
      .push      (fifo_push),
      .push_data (commit_entry),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // A commit arriving at an empty queue skips it and goes straight to the output register.
   always_comb begin
      state_nxt        = state;
      bus.commit_ready = rdy_in && !fifo_full && (state == IDLE);
      bus.rename_ready = rdy_in && (state == IDLE) && !flush_req;
      commit_fire      = bus.commit_valid && bus.commit_ready;
      rename_fire      = bus.rename_valid && bus.rename_ready;
      commit_writes    = commit_fire && rd_is_real(bus.commit_rd);
      fifo_pop         = !fifo_empty;
      fifo_push        = commit_writes && !fifo_empty;

      case (state)
         IDLE: begin
            if (flush_req) begin
               state_nxt = (!fifo_empty || commit_fire) ? DRAIN : CLEAR;
            end
         end
         DRAIN: begin
            if (fifo_empty) begin
               state_nxt = CLEAR;
            end
         end
         CLEAR:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state            <= IDLE;
         rob_clear        <= 1'b0;
         is_update_val_in <= 1'b0;
         update_val_id    <= '0;
         update_val_dep   <= '0;
         update_val       <= '0;
         is_update_dep_in <= 1'b0;
         update_dep_id    <= '0;
         update_dep       <= '0;
      end else if (rdy_in) begin
         state     <= state_nxt;
         rob_clear <= (state_nxt == CLEAR);

         if (fifo_pop) begin
            is_update_val_in <= 1'b1;
            update_val_id    <= fifo_head.rd;
            update_val_dep   <= fifo_head.tag;
            update_val       <= fifo_head.val;
         end else if (commit_writes) begin
            is_update_val_in <= 1'b1;
            update_val_id    <= commit_entry.rd;
            update_val_dep   <= commit_entry.tag;
            update_val       <= commit_entry.val;
         end else begin
            is_update_val_in <= 1'b0;
            update_val_id    <= '0;
            update_val_dep   <= '0;
            update_val       <= '0;
         end

         if (rename_fire && rd_is_real(bus.rename_rd)) begin
            is_update_dep_in <= 1'b1;
            update_dep_id    <= bus.rename_rd;
            update_dep       <= bus.rename_tag;
         end else begin
            is_update_dep_in <= 1'b0;
            update_dep_id    <= '0;
            update_dep       <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rf_update_sched.sv
// Randomised and directed bench for rf_update_sched, checked cycle by cycle
// against a queue-based reference model of the commit/rename/flush rules.
module tb_rf_update_sched;
   import rf_update_sched_pkg::*;

   localparam int TW = ROB_SIZE_BIT;
   localparam int CQ = 4;

   logic            clk_in = 1'b0;
   logic            rst_in;
   logic            rdy_in;
   logic            flush_req;
   logic            flush_busy;
   logic            is_update_val_in;
   logic [4:0]      update_val_id;
   logic [TW-1:0]   update_val_dep;
   logic [31:0]     update_val;
   logic            is_update_dep_in;
   logic [4:0]      update_dep_id;
   logic [TW-1:0]   update_dep;
   logic            rob_clear;

   rf_update_sched_if #(.TAG_W(TW)) bus ();

   rf_update_sched #(.TAG_W(TW), .CQ_DEPTH(CQ)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .rdy_in           (rdy_in),
      .bus              (bus),
      .flush_req        (flush_req),
      .flush_busy       (flush_busy),
      .is_update_val_in (is_update_val_in),
      .update_val_id    (update_val_id),
      .update_val_dep   (update_val_dep),
      .update_val       (update_val),
      .is_update_dep_in (is_update_dep_in),
      .update_dep_id    (update_dep_id),
      .update_dep       (update_dep),
      .rob_clear        (rob_clear)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [4:0]    rd;
      logic [TW-1:0] tag;
      logic [31:0]   val;
   } wr_t;

   // Model: writes accepted but not yet seen at the RF, plus flush progress
   // (0 normal, 1 waiting for accepted writes to land, 2 clearing cycle).
   wr_t           pend_q[$];
   int            phase;
   logic          m_val_en;
   logic [4:0]    m_val_id;
   logic [TW-1:0] m_val_dep;
   logic [31:0]   m_val;
   logic          m_dep_en;
   logic [4:0]    m_dep_id;
   logic [TW-1:0] m_dep;
   logic          m_clear;
   bit            model_live;
   int            checks_total;
   int            checks_passed;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_total++;
      if (obs === exp) checks_passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic clearModelOutputs();
      m_val_en  = 1'b0;
      m_val_id  = '0;
      m_val_dep = '0;
      m_val     = '0;
      m_dep_en  = 1'b0;
      m_dep_id  = '0;
      m_dep     = '0;
      m_clear   = 1'b0;
   endtask

   task automatic applyStimulus(input logic rst, input logic rdy,
                                input logic cv, input logic [4:0] crd,
                                input logic [TW-1:0] ctag, input logic [31:0] cval,
                                input logic rv, input logic [4:0] rrd,
                                input logic [TW-1:0] rtag, input logic fl);
      wr_t  nq[$];
      wr_t  w;
      bit   cfire;
      bit   rfire;
      bit   had;
      int   nphase;
      logic exp_cr;
      logic exp_rr;

      rst_in           = rst;
      rdy_in           = rdy;
      flush_req        = fl;
      bus.commit_valid = cv;
      bus.commit_rd    = crd;
      bus.commit_tag   = ctag;
      bus.commit_val   = cval;
      bus.rename_valid = rv;
      bus.rename_rd    = rrd;
      bus.rename_tag   = rtag;
      #2;

      exp_cr = rdy && (pend_q.size() < CQ) && (phase == 0);
      exp_rr = rdy && (phase == 0) && !fl;
      if (model_live) begin
         checkOutput("commit_ready", 64'(bus.commit_ready), 64'(exp_cr));
         checkOutput("rename_ready", 64'(bus.rename_ready), 64'(exp_rr));
         checkOutput("flush_busy", 64'(flush_busy), 64'(phase != 0));
      end

      cfire = cv && exp_cr;
      rfire = rv && exp_rr;
      had   = pend_q.size() > 0;
      nq    = pend_q;
      if (cfire && crd != 5'd0) nq.push_back('{crd, ctag, cval});
      case (phase)
         0:       nphase = fl ? ((had || cfire) ? 1 : 2) : 0;
         1:       nphase = had ? 1 : 2;
         default: nphase = 0;
      endcase

      @(posedge clk_in);
      #1;

      if (!rst) begin
         pend_q.delete();
         phase = 0;
         clearModelOutputs();
         model_live = 1'b1;
      end else if (rdy) begin
         clearModelOutputs();
         if (nq.size() > 0) begin
            w         = nq.pop_front();
            m_val_en  = 1'b1;
            m_val_id  = w.rd;
            m_val_dep = w.tag;
            m_val     = w.val;
         end
         pend_q = nq;
         if (rfire && rrd != 5'd0) begin
            m_dep_en = 1'b1;
            m_dep_id = rrd;
            m_dep    = rtag;
         end
         phase   = nphase;
         m_clear = (nphase == 2);
      end

      if (model_live) begin
         checkOutput("val_en", 64'(is_update_val_in), 64'(m_val_en));
         checkOutput("val_id", 64'(update_val_id), 64'(m_val_id));
         checkOutput("val_dep", 64'(update_val_dep), 64'(m_val_dep));
         checkOutput("val", 64'(update_val), 64'(m_val));
         checkOutput("dep_en", 64'(is_update_dep_in), 64'(m_dep_en));
         checkOutput("dep_id", 64'(update_dep_id), 64'(m_dep_id));
         checkOutput("dep", 64'(update_dep), 64'(m_dep));
         checkOutput("rob_clear", 64'(rob_clear), 64'(m_clear));
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      model_live    = 1'b0;
      phase         = 0;
      clearModelOutputs();

      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

      applyStimulus(1, 1, 1, 5'd5, TW'(3), 32'hDEADBEEF, 0, 0, 0, 0);
      idleCycles(2);

      for (int i = 0; i < 5; i++)
         applyStimulus(1, 1, 1, 5'(i + 1), TW'(i), 32'h1000 + i, 0, 0, 0, 0);
      idleCycles(2);

      applyStimulus(1, 1, 1, 5'd0, TW'(1), 32'h55, 1, 5'd0, TW'(2), 0);
      idleCycles(1);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 5'd7, TW'(9), 0);
      applyStimulus(1, 1, 1, 5'd9, TW'(2), 32'hA5A5, 1, 5'd9, TW'(6), 0);
      idleCycles(1);

      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      idleCycles(2);

      applyStimulus(1, 1, 1, 5'd12, TW'(4), 32'hCAFE, 1, 5'd13, TW'(5), 1);
      idleCycles(3);

      applyStimulus(1, 1, 1, 5'd6, TW'(1), 32'h77, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idleCycles(3);

      applyStimulus(1, 1, 1, 5'd8, TW'(2), 32'h88, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      idleCycles(2);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 49) != 0),
                       1'($urandom_range(0, 6) != 0),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                       TW'($urandom),
                       $urandom,
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                       TW'($urandom),
                       1'($urandom_range(0, 9) == 0));
      end
      idleCycles(4);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
